// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction from execute, aligns SRAM load data, offers result to writeback.
// Latency: one cycle per instruction (ms_ready_go is always 1); the SRAM word arrives in the first held cycle.
// Backpressure: ms_allowin drops while holding a valid instruction that writeback refuses; the load word is buffered across the stall.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [95:0] es_to_ms_bus,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [90:0] ms_to_ws_bus,
  output logic [37:0] ms_fwd_bus,
  output logic        ms_ex,
  input  logic        flush
);

  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic [95:0] es_to_ms_bus_r;

  // SRAM read-data capture: the word is only guaranteed on the first cycle
  logic        first_cyc;
  logic [31:0] rdata_buf;
  logic        rdata_buf_vld;
  logic [31:0] ld_data;

  // Decoded fields of the held instruction
  logic [10:0] root_bus;
  logic        bd;
  logic        ex;
  logic [4:0]  excode;
  logic [6:0]  ld_inst;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic [1:0]  pos;

  logic        inst_lw;
  logic        inst_lb;
  logic        inst_lbu;
  logic        inst_lh;
  logic        inst_lhu;
  logic        inst_lwl;
  logic        inst_lwr;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] lwl_data;
  logic [3:0]  lwl_strb;
  logic [31:0] lwr_data;
  logic [3:0]  lwr_strb;
  logic [31:0] mem_result;
  logic [3:0]  mem_strb;
  logic [31:0] final_result;
  logic [3:0]  rf_wstrb;
  logic        block_valid;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid || (ws_allowin && ms_ready_go);
  assign accept      = es_to_ms_valid && ms_allowin;

  // Stage occupancy: load on allowin, drop on flush (including an incoming instruction)
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid && !flush;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end
  end

  // Instruction payload register; contents are don't-care while ms_valid is low
  always_ff @(posedge clk) begin
    if (accept) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  // Mark the cycle right after accept, when the SRAM word is on data_sram_rdata
  always_ff @(posedge clk) begin
    if (reset) begin
      first_cyc <= 1'b0;
    end else begin
      first_cyc <= accept;
    end
  end

  // Capture the SRAM word on the first cycle so a writeback stall does not lose it
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf     <= 32'd0;
      rdata_buf_vld <= 1'b0;
    end else begin
      if (first_cyc) begin
        rdata_buf <= data_sram_rdata;
      end
      if (accept) begin
        rdata_buf_vld <= 1'b0;
      end else if (first_cyc) begin
        rdata_buf_vld <= 1'b1;
      end
    end
  end

  assign ld_data = (first_cyc || !rdata_buf_vld) ? data_sram_rdata : rdata_buf;

  assign root_bus     = es_to_ms_bus_r[95:85];
  assign bd           = es_to_ms_bus_r[84];
  assign ex           = es_to_ms_bus_r[83];
  assign excode       = es_to_ms_bus_r[82:78];
  assign ld_inst      = es_to_ms_bus_r[77:71];
  assign res_from_mem = es_to_ms_bus_r[70];
  assign gr_we        = es_to_ms_bus_r[69];
  assign dest         = es_to_ms_bus_r[68:64];
  assign result       = es_to_ms_bus_r[63:32];
  assign pc           = es_to_ms_bus_r[31:0];
  assign pos          = result[1:0];

  assign inst_lw  = ld_inst[6];
  assign inst_lb  = ld_inst[5];
  assign inst_lbu = ld_inst[4];
  assign inst_lh  = ld_inst[3];
  assign inst_lhu = ld_inst[2];
  assign inst_lwl = ld_inst[1];
  assign inst_lwr = ld_inst[0];

  // Byte and halfword lane selection by address offset
  always_comb begin
    sel_byte = ld_data[7:0];
    case (pos)
      2'd0: sel_byte = ld_data[7:0];
      2'd1: sel_byte = ld_data[15:8];
      2'd2: sel_byte = ld_data[23:16];
      2'd3: sel_byte = ld_data[31:24];
      default: sel_byte = ld_data[7:0];
    endcase
    sel_half = pos[1] ? ld_data[31:16] : ld_data[15:0];
  end

  // Unaligned left/right word merge: data and register byte-enables per offset
  always_comb begin
    lwl_data = ld_data;
    lwl_strb = 4'b1111;
    lwr_data = ld_data;
    lwr_strb = 4'b1111;
    case (pos)
      2'd0: begin
        lwl_data = {ld_data[7:0], 24'd0};
        lwl_strb = 4'b1000;
        lwr_data = ld_data;
        lwr_strb = 4'b1111;
      end
      2'd1: begin
        lwl_data = {ld_data[15:0], 16'd0};
        lwl_strb = 4'b1100;
        lwr_data = {8'd0, ld_data[31:8]};
        lwr_strb = 4'b0111;
      end
      2'd2: begin
        lwl_data = {ld_data[23:0], 8'd0};
        lwl_strb = 4'b1110;
        lwr_data = {16'd0, ld_data[31:16]};
        lwr_strb = 4'b0011;
      end
      2'd3: begin
        lwl_data = ld_data;
        lwl_strb = 4'b1111;
        lwr_data = {24'd0, ld_data[31:24]};
        lwr_strb = 4'b0001;
      end
      default: begin
        lwl_data = ld_data;
        lwl_strb = 4'b1111;
        lwr_data = ld_data;
        lwr_strb = 4'b1111;
      end
    endcase
  end

  // Pick the load format; a load with no recognised type falls back to a full word
  always_comb begin
    mem_result = ld_data;
    mem_strb   = 4'b1111;
    if (inst_lb) begin
      mem_result = {{24{sel_byte[7]}}, sel_byte};
    end else if (inst_lbu) begin
      mem_result = {24'd0, sel_byte};
    end else if (inst_lh) begin
      mem_result = {{16{sel_half[15]}}, sel_half};
    end else if (inst_lhu) begin
      mem_result = {16'd0, sel_half};
    end else if (inst_lwl) begin
      mem_result = lwl_data;
      mem_strb   = lwl_strb;
    end else if (inst_lwr) begin
      mem_result = lwr_data;
      mem_strb   = lwr_strb;
    end else if (inst_lw) begin
      mem_result = ld_data;
    end
  end

  // Final result and register byte-enables; no write for bubbles, exceptions or non-writing ops
  always_comb begin
    final_result = res_from_mem ? mem_result : result;
    rf_wstrb     = res_from_mem ? mem_strb : 4'b1111;
    if (!gr_we || ex || !ms_valid) begin
      rf_wstrb = 4'b0000;
    end
  end

  assign block_valid    = ms_valid && gr_we && !flush;
  assign ms_to_ws_valid = ms_valid && !flush;
  assign ms_ex          = ms_valid && ex;
  assign ms_to_ws_bus   = {root_bus, bd, ex, excode, rf_wstrb, dest, final_result, pc};
  assign ms_fwd_bus     = {block_valid, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: reset values, table of load formats, stall/flush/reset corner sequences,
// then randomized traffic against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [95:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [90:0] ms_to_ws_bus;
  logic [37:0] ms_fwd_bus;
  logic        ms_ex;
  logic        flush;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_fwd_bus      (ms_fwd_bus),
    .ms_ex           (ms_ex),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] LW  = 7'b1000000;
  localparam logic [6:0] LB  = 7'b0100000;
  localparam logic [6:0] LBU = 7'b0010000;
  localparam logic [6:0] LH  = 7'b0001000;
  localparam logic [6:0] LHU = 7'b0000100;
  localparam logic [6:0] LWL = 7'b0000010;
  localparam logic [6:0] LWR = 7'b0000001;

  typedef struct {
    logic [6:0]  ld;
    logic        rfm;
    logic        gr_we;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [3:0]  exp_strb;
  } vec_t;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_bus(input logic [10:0] root, input logic bd, input logic ex,
                                         input logic [4:0] excode, input logic [6:0] ld, input logic rfm,
                                         input logic gr_we, input logic [4:0] dest,
                                         input logic [31:0] result, input logic [31:0] pc);
    return {root, bd, ex, excode, ld, rfm, gr_we, dest, result, pc};
  endfunction

  // Reference load alignment: shifts computed from the byte offset, returns {strb, result}
  function automatic logic [35:0] ref_load(input logic [6:0] ld, input logic rfm,
                                           input logic [31:0] addr, input logic [31:0] d);
    int          p;
    logic [31:0] r;
    logic [3:0]  s;
    logic [7:0]  b;
    logic [15:0] h;
    p = int'(addr[1:0]);
    s = 4'hf;
    r = d;
    if (!rfm) begin
      r = addr;
    end else if (ld[5] || ld[4]) begin
      b = 8'(d >> (8 * p));
      r = ld[5] ? {{24{b[7]}}, b} : {24'd0, b};
    end else if (ld[3] || ld[2]) begin
      h = 16'(d >> (16 * (p / 2)));
      r = ld[3] ? {{16{h[15]}}, h} : {16'd0, h};
    end else if (ld[1]) begin
      r = d << (8 * (3 - p));
      s = 4'(4'hf << (3 - p));
    end else if (ld[0]) begin
      r = d >> (8 * p);
      s = 4'(4'hf >> p);
    end
    return {s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: instruction held, and the SRAM word seen on its first cycle
  logic        m_valid;
  logic        m_first;
  logic [95:0] m_bus;
  logic [31:0] m_word;

  vec_t vecs[12];

  initial begin
    logic [31:0] word;
    logic [35:0] rs;
    logic [3:0]  strb;
    logic [90:0] exp_bus;
    logic        alw;
    logic        acc;
    logic [6:0]  ld;

    vecs[0]  = '{LB,   1'b1, 1'b1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1111};
    vecs[1]  = '{LHU,  1'b1, 1'b1, 32'h0000_2002, 32'h9ABC_5678, 32'h0000_9ABC, 4'b1111};
    vecs[2]  = '{LWL,  1'b1, 1'b1, 32'h0000_1001, 32'h1122_3344, 32'h3344_0000, 4'b1100};
    vecs[3]  = '{LWR,  1'b1, 1'b1, 32'h0000_1002, 32'h1122_3344, 32'h0000_1122, 4'b0011};
    vecs[4]  = '{LW,   1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111};
    vecs[5]  = '{LBU,  1'b1, 1'b1, 32'h0000_1002, 32'h80FF_1234, 32'h0000_00FF, 4'b1111};
    vecs[6]  = '{LH,   1'b1, 1'b1, 32'h0000_1000, 32'h1234_8001, 32'hFFFF_8001, 4'b1111};
    vecs[7]  = '{LWL,  1'b1, 1'b1, 32'h0000_1000, 32'h1122_3344, 32'h4400_0000, 4'b1000};
    vecs[8]  = '{LWR,  1'b1, 1'b1, 32'h0000_1003, 32'h1122_3344, 32'h0000_0011, 4'b0001};
    vecs[9]  = '{7'd0, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 4'b1111};
    vecs[10] = '{LB,   1'b1, 1'b1, 32'h0000_1000, 32'h0000_007F, 32'h0000_007F, 4'b1111};
    vecs[11] = '{LW,   1'b1, 1'b0, 32'h0000_1000, 32'h5555_AAAA, 32'h5555_AAAA, 4'b0000};

    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    data_sram_rdata = '0;
    flush           = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_allowin", ms_allowin, 1);
    chk("reset_valid", ms_to_ws_valid, 0);
    chk("reset_ex", ms_ex, 0);
    chk("reset_block", ms_fwd_bus[37], 0);

    // Table: one instruction per entry, writeback always ready
    for (int i = 0; i < 12; i++) begin
      tick();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_bus(11'h5A5, 1'b0, 1'b0, 5'd0, vecs[i].ld, vecs[i].rfm, vecs[i].gr_we,
                              5'd7, vecs[i].addr, 32'hBFC0_0000 + 32'(i * 4));
      tick();
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1);
      chk($sformatf("vec%0d_result", i), ms_to_ws_bus[63:32], vecs[i].exp_res);
      chk($sformatf("vec%0d_wstrb", i), ms_to_ws_bus[72:69], vecs[i].exp_strb);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_gone", i), ms_to_ws_valid, 0);
    end

    // Stall: word must survive SRAM output changing while writeback is busy
    tick();
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(11'h0, 1'b0, 1'b0, 5'd0, LW, 1'b1, 1'b1, 5'd3, 32'h0000_3000, 32'h100);
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h0123_4567;
    @(negedge clk);
    chk("stall_c1_result", ms_to_ws_bus[63:32], 32'h0123_4567);
    chk("stall_c1_allowin", ms_allowin, 0);
    tick();
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stall_c2_result", ms_to_ws_bus[63:32], 32'h0123_4567);
    tick();
    @(negedge clk);
    chk("stall_c3_result", ms_to_ws_bus[63:32], 32'h0123_4567);
    chk("stall_c3_valid", ms_to_ws_valid, 1);
    tick();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("stall_rel_result", ms_to_ws_bus[63:32], 32'h0123_4567);
    chk("stall_rel_allowin", ms_allowin, 1);
    tick();
    @(negedge clk);
    chk("stall_rel_gone", ms_to_ws_valid, 0);

    // Exception held, then flushed
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(11'h123, 1'b1, 1'b1, 5'h04, 7'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0044, 32'h200);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("exc_ms_ex", ms_ex, 1);
    chk("exc_wstrb", ms_to_ws_bus[72:69], 4'b0000);
    chk("exc_excode", ms_to_ws_bus[77:73], 5'h04);
    chk("exc_passthru", {ms_to_ws_bus[90:78]}, {11'h123, 1'b1, 1'b1});
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", ms_to_ws_valid, 0);
    chk("flush_block", ms_fwd_bus[37], 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_after_valid", ms_to_ws_valid, 0);
    chk("flush_after_ex", ms_ex, 0);
    chk("flush_after_allowin", ms_allowin, 1);

    // Flush coinciding with an accept drops the newcomer
    ws_allowin     = 1'b1;
    flush          = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(11'h0, 1'b0, 1'b0, 5'd0, LW, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h300);
    tick();
    flush          = 1'b0;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_valid", ms_to_ws_valid, 0);
    chk("flush_accept_block", ms_fwd_bus[37], 0);

    // Reset while stalled on a load
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(11'h0, 1'b0, 1'b0, 5'd0, LW, 1'b1, 1'b1, 5'd6, 32'h0000_4000, 32'h400);
    tick();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h0000_0055;
    @(negedge clk);
    chk("rst_stall_held", ms_to_ws_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall_valid", ms_to_ws_valid, 0);
    chk("rst_stall_allowin", ms_allowin, 1);
    chk("rst_stall_ex", ms_ex, 0);
    chk("rst_stall_block", ms_fwd_bus[37], 0);
    chk("rst_stall_wstrb", ms_to_ws_bus[72:69], 4'b0000);

    // Randomized traffic against the model
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    m_valid = 1'b0;
    m_first = 1'b0;
    m_bus   = '0;
    m_word  = '0;
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 99) == 0);
      es_to_ms_valid  = ($urandom_range(0, 9) < 7);
      ws_allowin      = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 19) == 0);
      data_sram_rdata = $urandom;
      ld              = 7'(7'd1 << $urandom_range(0, 6));
      es_to_ms_bus    = mk_bus(11'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 5'($urandom),
                               ld, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      @(negedge clk);
      chk("rnd_allowin", ms_allowin, !m_valid || ws_allowin);
      chk("rnd_valid", ms_to_ws_valid, m_valid && !flush);
      chk("rnd_ex", ms_ex, m_valid && m_bus[83]);
      chk("rnd_block", ms_fwd_bus[37], m_valid && m_bus[69] && !flush);
      if (m_valid) begin
        word    = m_first ? data_sram_rdata : m_word;
        rs      = ref_load(m_bus[77:71], m_bus[70], m_bus[63:32], word);
        strb    = (m_bus[69] && !m_bus[83]) ? rs[35:32] : 4'b0000;
        exp_bus = {m_bus[95:78], strb, m_bus[68:64], rs[31:0], m_bus[31:0]};
        chk("rnd_ws_bus", ms_to_ws_bus, exp_bus);
        chk("rnd_fwd_bus", ms_fwd_bus[36:0], {m_bus[68:64], rs[31:0]});
      end
      @(posedge clk);
      if (reset) begin
        m_valid = 1'b0;
        m_first = 1'b0;
      end else begin
        alw = !m_valid || ws_allowin;
        acc = es_to_ms_valid && alw;
        if (m_first) m_word = data_sram_rdata;
        if (alw) m_valid = es_to_ms_valid && !flush;
        else if (flush) m_valid = 1'b0;
        m_first = acc;
        if (acc) m_bus = es_to_ms_bus;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
